rst_seq: RTL and testbench

- Power-on and lock-loss reset sequencer, directly downstream of the PLL clock generator.
- Runs on the free-running 24 MHz reference clock and consumes the PLL `locked` flag and the SDRAM controller init-done flag.
- Produces the PLL reset request and the staged resets for the system/SDRAM/VGA domains and the 68040 `RSTI`.
- Every output is registered in the clk24_ref domain; each destination domain re-synchronises its reset locally with a 2-FF synchroniser (assert async, deassert sync).

---
 rtl/rst_seq.sv | 166 ++++++++++++++++
 tb/tb_rst_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// rst_seq: power-on and lock-loss reset sequencer on the 24 MHz reference clock.
// Walks PLL reset -> lock wait -> lock qualification -> SDRAM init -> CPU reset
// -> run. Lock loss after domain release drops the system back to lock wait.
// Ports:
//   clk24_ref        free-running 24 MHz reference clock
//   rst_n            async active-low board reset
//   pll_locked       PLL lock flag (asynchronous, synchronised here)
//   sdram_init_done  SDRAM controller init done (sdram_clk domain, synchronised here)
//   pll_rst          PLL reset request, active-high
//   sys_rst          sys_clk domain reset, active-high
//   sdram_rst        SDRAM controller reset, active-high
//   vga_rst          VGA pipeline reset, active-high
//   cpu_rst_n        68040 RSTI, active-low
//   ready            system running
//   fault            SDRAM init timed out
//   lock_loss_cnt    saturating count of lock losses after domain release
module rst_seq #(
  parameter int unsigned PLL_RST_CYCLES     = 4,
  parameter int unsigned LOCK_TIMEOUT       = 24000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned SDRAM_INIT_TIMEOUT = 2400000,
  parameter int unsigned CPU_RST_CYCLES     = 240
) (
  input  logic       clk24_ref,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       sdram_rst,
  output logic       vga_rst,
  output logic       cpu_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_ABC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_ABCD = (MAX_ABC > SDRAM_INIT_TIMEOUT) ? MAX_ABC : SDRAM_INIT_TIMEOUT;
  localparam int unsigned MAX_P   = (MAX_ABCD > CPU_RST_CYCLES) ? MAX_ABCD : CPU_RST_CYCLES;
  localparam int unsigned CNT_W   = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int unsigned LLC_W   = 8;

  localparam logic [CNT_W-1:0] PLL_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SDRAM_TO_LAST    = CNT_W'(SDRAM_INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CPU_RST_LAST     = CNT_W'(CPU_RST_CYCLES - 1);

  localparam logic [2:0] S_PLL_RST     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK   = 3'd1;
  localparam logic [2:0] S_LOCK_STABLE = 3'd2;
  localparam logic [2:0] S_SDRAM_INIT  = 3'd3;
  localparam logic [2:0] S_CPU_RST     = 3'd4;
  localparam logic [2:0] S_RUN         = 3'd5;
  localparam logic [2:0] S_FAULT       = 3'd6;

  logic             lk_meta, lk;
  logic             dn_meta, dn;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             loss;
  logic             pll_rst_d, dom_rst_d, cpu_rst_n_d, ready_d, fault_d;
  logic [LLC_W-1:0] lock_loss_cnt_d;

  // Two-stage synchronisers for the asynchronous lock and init-done flags.
  always_ff @(posedge clk24_ref or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
      dn_meta <= 1'b0;
      dn      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
      dn_meta <= sdram_init_done;
      dn      <= dn_meta;
    end
  end

  // Next state, shared counter and next output values.
  always_comb begin
    state_d         = state_q;
    loss            = 1'b0;
    cnt_d           = cnt_q;
    pll_rst_d       = 1'b0;
    dom_rst_d       = 1'b0;
    cpu_rst_n_d     = 1'b0;
    ready_d         = 1'b0;
    fault_d         = 1'b0;
    lock_loss_cnt_d = lock_loss_cnt;

    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lk)                              state_d = S_LOCK_STABLE;
        else if (cnt_q == LOCK_TIMEOUT_LAST) state_d = S_PLL_RST;
      end
      S_LOCK_STABLE: begin
        if (!lk)                            state_d = S_WAIT_LOCK;
        else if (cnt_q == LOCK_STABLE_LAST) state_d = S_SDRAM_INIT;
      end
      S_SDRAM_INIT: begin
        if (!lk)                         loss    = 1'b1;
        else if (dn)                     state_d = S_CPU_RST;
        else if (cnt_q == SDRAM_TO_LAST) state_d = S_FAULT;
      end
      S_CPU_RST: begin
        if (!lk)                        loss    = 1'b1;
        else if (cnt_q == CPU_RST_LAST) state_d = S_RUN;
      end
      S_RUN, S_FAULT: begin
        if (!lk) loss = 1'b1;
      end
      default: state_d = S_PLL_RST;
    endcase

    // Lock loss after release overrides every other transition.
    if (loss) begin
      state_d = S_WAIT_LOCK;
      if (lock_loss_cnt != {LLC_W{1'b1}}) lock_loss_cnt_d = lock_loss_cnt + LLC_W'(1);
    end

    // Counter restarts on every state entry; it saturates so idle states never wrap.
    if (state_d != state_q)         cnt_d = '0;
    else if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);

    pll_rst_d   = (state_d == S_PLL_RST);
    dom_rst_d   = (state_d == S_PLL_RST) || (state_d == S_WAIT_LOCK) ||
                  (state_d == S_LOCK_STABLE);
    cpu_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk24_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_PLL_RST;
      cnt_q         <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      sdram_rst     <= 1'b1;
      vga_rst       <= 1'b1;
      cpu_rst_n     <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst       <= pll_rst_d;
      sys_rst       <= dom_rst_d;
      sdram_rst     <= dom_rst_d;
      vga_rst       <= dom_rst_d;
      cpu_rst_n     <= cpu_rst_n_d;
      ready         <= ready_d;
      fault         <= fault_d;
      lock_loss_cnt <= lock_loss_cnt_d;
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: self-checking bench for rst_seq with shortened timing parameters.
// Each scenario pushes the expected next output change (edge distance and full
// output vector) onto a queue, then pops it when the DUT outputs change.
`timescale 1ns/1ps
module tb_rst_seq;

  localparam int unsigned P_PLL = 4;
  localparam int unsigned P_TO  = 64;
  localparam int unsigned P_STB = 16;
  localparam int unsigned P_SDT = 128;
  localparam int unsigned P_CPU = 8;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_rst;
    logic       sdram_rst;
    logic       vga_rst;
    logic       cpu_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_cnt;
  } out_t;

  typedef struct {
    string name;
    int    edges;
    out_t  vec;
  } exp_t;

  logic       clk24_ref = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sdram_init_done = 1'b0;
  logic       pll_rst, sys_rst, sdram_rst, vga_rst, cpu_rst_n, ready, fault;
  logic [7:0] lock_loss_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #21 clk24_ref = ~clk24_ref;

  rst_seq #(
    .PLL_RST_CYCLES    (P_PLL),
    .LOCK_TIMEOUT      (P_TO),
    .LOCK_STABLE_CYCLES(P_STB),
    .SDRAM_INIT_TIMEOUT(P_SDT),
    .CPU_RST_CYCLES    (P_CPU)
  ) dut (
    .clk24_ref      (clk24_ref),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .sdram_init_done(sdram_init_done),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .sdram_rst      (sdram_rst),
    .vga_rst        (vga_rst),
    .cpu_rst_n      (cpu_rst_n),
    .ready          (ready),
    .fault          (fault),
    .lock_loss_cnt  (lock_loss_cnt)
  );

  function automatic out_t cur_out();
    out_t o;
    o.pll_rst       = pll_rst;
    o.sys_rst       = sys_rst;
    o.sdram_rst     = sdram_rst;
    o.vga_rst       = vga_rst;
    o.cpu_rst_n     = cpu_rst_n;
    o.ready         = ready;
    o.fault         = fault;
    o.lock_loss_cnt = lock_loss_cnt;
    return o;
  endfunction

  function automatic out_t mk(input logic pr, input logic dr, input logic cn,
                              input logic rd, input logic ft, input logic [7:0] c);
    out_t o;
    o.pll_rst       = pr;
    o.sys_rst       = dr;
    o.sdram_rst     = dr;
    o.vga_rst       = dr;
    o.cpu_rst_n     = cn;
    o.ready         = rd;
    o.fault         = ft;
    o.lock_loss_cnt = c;
    return o;
  endfunction

  // Expected output vectors per sequencer phase.
  function automatic out_t v_pll(input logic [7:0] c);   return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c); endfunction
  function automatic out_t v_wait(input logic [7:0] c);  return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c); endfunction
  function automatic out_t v_sdram(input logic [7:0] c); return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c); endfunction
  function automatic out_t v_run(input logic [7:0] c);   return mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c); endfunction
  function automatic out_t v_fault(input logic [7:0] c); return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c); endfunction

  function automatic logic [7:0] sat(input int x);
    return (x > 255) ? 8'd255 : 8'(x);
  endfunction

  task automatic step();
    @(posedge clk24_ref);
    #1;
  endtask

  task automatic push(input string nm, input int ed, input out_t v);
    exp_t e;
    e.name  = nm;
    e.edges = ed;
    e.vec   = v;
    exp_q.push_back(e);
  endtask

  // Pops the next expectation and waits (bounded) for the outputs to change.
  task automatic await_next(output exp_t e, output int n, output out_t v);
    out_t prev;
    e    = exp_q.pop_front();
    prev = cur_out();
    n    = 0;
    do begin
      step();
      n++;
    end while (cur_out() === prev && n < e.edges + 40);
    v = cur_out();
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    pll_locked      = 1'b0;
    sdram_init_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out_t v;
    rst_n = 1'b0;
    repeat (3) step();
    v = cur_out();
    checks++;
    if (v !== v_pll(8'd0)) begin
      errors++;
      $display("FAIL reset_values got %h expected %h", v, v_pll(8'd0));
    end
    pll_locked      = 1'b1;
    sdram_init_done = 1'b1;
    repeat (5) step();
    v = cur_out();
    checks++;
    if (v !== v_pll(8'd0)) begin
      errors++;
      $display("FAIL reset_held got %h expected %h", v, v_pll(8'd0));
    end
  endtask

  task automatic test_clean_boot();
    exp_t e; int n; out_t v;
    apply_reset();
    push("boot_pll_fall", P_PLL, v_wait(8'd0));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    repeat (6) step();
    v = cur_out();
    checks++;
    if (v !== v_wait(8'd0)) begin errors++; $display("FAIL boot_wait_hold got %h expected %h", v, v_wait(8'd0)); end
    pll_locked = 1'b1;
    push("boot_domain_release", 3 + P_STB, v_sdram(8'd0));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    repeat (20) step();
    sdram_init_done = 1'b1;
    push("boot_cpu_release", 3 + P_CPU, v_run(8'd0));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    repeat (10) step();
    v = cur_out();
    checks++;
    if (v !== v_run(8'd0)) begin errors++; $display("FAIL boot_run_hold got %h expected %h", v, v_run(8'd0)); end
  endtask

  task automatic test_no_lock();
    exp_t e; int n; out_t v;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push("nolock_pll_fall", (i == 0) ? P_PLL : P_PLL, v_wait(8'd0));
      push("nolock_pll_rise", P_TO, v_pll(8'd0));
    end
    for (int i = 0; i < 6; i++) begin
      await_next(e, n, v);
      checks += 2;
      if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
      if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    end
  endtask

  task automatic test_lock_chatter();
    exp_t e; int n; out_t v;
    apply_reset();
    push("chatter_pll_fall", P_PLL, v_wait(8'd0));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    pll_locked = 1'b1;
    repeat (10) step();
    pll_locked = 1'b0;
    repeat (3) step();
    v = cur_out();
    checks++;
    if (v !== v_wait(8'd0)) begin errors++; $display("FAIL chatter_no_release got %h expected %h", v, v_wait(8'd0)); end
    pll_locked = 1'b1;
    push("chatter_release", 3 + P_STB, v_sdram(8'd0));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
  endtask

  task automatic test_sdram_timeout();
    exp_t e; int n; out_t v;
    apply_reset();
    pll_locked = 1'b1;
    // Lock is already synchronised when lock wait starts, so it qualifies one edge later.
    push("to_pll_fall", P_PLL, v_wait(8'd0));
    push("to_release", 1 + P_STB, v_sdram(8'd0));
    push("to_fault", P_SDT, v_fault(8'd0));
    for (int i = 0; i < 3; i++) begin
      await_next(e, n, v);
      checks += 2;
      if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
      if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    end
    pll_locked = 1'b0;
    push("to_lock_loss", 3, v_wait(8'd1));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
  endtask

  task automatic test_lock_loss_run();
    exp_t e; int n; out_t v;
    apply_reset();
    pll_locked = 1'b1;
    push("run_pll_fall", P_PLL, v_wait(8'd0));
    push("run_release", 1 + P_STB, v_sdram(8'd0));
    for (int i = 0; i < 2; i++) begin
      await_next(e, n, v);
      checks += 2;
      if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
      if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    end
    sdram_init_done = 1'b1;
    push("run_enter", 3 + P_CPU, v_run(8'd0));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    pll_locked = 1'b0;
    push("run_lock_loss", 3, v_wait(8'd1));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    // Controller drops init-done while held in reset.
    sdram_init_done = 1'b0;
    pll_locked      = 1'b1;
    for (int k = 1; k < 300; k++) begin
      push("loss_rerelease", 3 + P_STB, v_sdram(sat(k)));
      push("loss_again", 3, v_wait(sat(k + 1)));
      await_next(e, n, v);
      checks += 2;
      if (n !== e.edges) begin errors++; $display("FAIL %s[%0d] edges got %0d expected %0d", e.name, k, n, e.edges); end
      if (v !== e.vec)   begin errors++; $display("FAIL %s[%0d] outputs got %h expected %h", e.name, k, v, e.vec); end
      pll_locked = 1'b0;
      await_next(e, n, v);
      checks += 2;
      if (n !== e.edges) begin errors++; $display("FAIL %s[%0d] edges got %0d expected %0d", e.name, k, n, e.edges); end
      if (v !== e.vec)   begin errors++; $display("FAIL %s[%0d] outputs got %h expected %h", e.name, k, v, e.vec); end
      pll_locked = 1'b1;
    end
    checks++;
    if (lock_loss_cnt !== 8'd255) begin
      errors++;
      $display("FAIL loss_saturated got %0d expected 255", lock_loss_cnt);
    end
  endtask

  task automatic test_async_reset();
    exp_t e; int n; out_t v;
    push("ar_release", 3 + P_STB, v_sdram(8'd255));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
    sdram_init_done = 1'b1;
    repeat (6) step();
    v = cur_out();
    checks++;
    if (v !== v_sdram(8'd255)) begin errors++; $display("FAIL ar_in_cpu_rst got %h expected %h", v, v_sdram(8'd255)); end
    #5;
    rst_n = 1'b0;
    #2;
    v = cur_out();
    checks++;
    if (v !== v_pll(8'd0)) begin errors++; $display("FAIL ar_async_values got %h expected %h", v, v_pll(8'd0)); end
    pll_locked      = 1'b0;
    sdram_init_done = 1'b0;
    step();
    step();
    v = cur_out();
    checks++;
    if (v !== v_pll(8'd0)) begin errors++; $display("FAIL ar_held got %h expected %h", v, v_pll(8'd0)); end
    rst_n = 1'b1;
    push("ar_restart", P_PLL, v_wait(8'd0));
    await_next(e, n, v);
    checks += 2;
    if (n !== e.edges) begin errors++; $display("FAIL %s edges got %0d expected %0d", e.name, n, e.edges); end
    if (v !== e.vec)   begin errors++; $display("FAIL %s outputs got %h expected %h", e.name, v, e.vec); end
  endtask

  initial begin
    test_reset();
    test_clean_boot();
    test_no_lock();
    test_lock_chatter();
    test_sdram_timeout();
    test_lock_loss_run();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2100000;
    $display("FAIL watchdog expired at %0t, checks %0d errors %0d", $time, checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
